// File: rtl/pakout_io.sv
// Packetizer for the transmit end of the packet-in link: messages arrive on a 4-phase channel,
// queue in a small FIFO, and leave as TOT_PKS packets of PSZ bits on a 4-phase packet channel.
module pakout_io #(
  parameter int PSZ = 4,
  parameter int FSZ = 4,
  parameter int ASZ = 6,
  parameter int DSZ = 4,
  parameter int RSZ = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [PSZ-1:0] o0_pakio,
  output logic           o0_req,
  input  logic           o0_ack
);

  localparam int MSG_SZ  = 2*ASZ + DSZ + RSZ;
  localparam int TOT_PKS = (MSG_SZ / PSZ) + 1;
  localparam int SH_SZ   = TOT_PKS * PSZ;
  localparam int AW      = $clog2(FSZ);
  localparam int IW      = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;

  logic              r_ireq_s1, r_ireq_s2;
  logic              r_oack_s1, r_oack_s2;
  logic              r_i0_ack;
  logic              r_o0_req;
  logic [PSZ-1:0]    r_pakio;
  logic [AW:0]       r_wptr, r_rptr;
  logic [MSG_SZ-1:0] r_mem [FSZ];
  logic [SH_SZ-1:0]  r_shift;
  logic [IW-1:0]     r_idx;
  logic [2:0]        r_state;

  logic w_full, w_empty, w_wr, w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = r_ireq_s2 && !r_i0_ack && !w_full;
  assign w_pop   = (r_state == S_LOAD);

  assign i0_ack   = r_i0_ack;
  assign o0_req   = r_o0_req;
  assign o0_pakio = r_pakio;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ireq_s1 <= 1'b0;
      r_ireq_s2 <= 1'b0;
      r_oack_s1 <= 1'b0;
      r_oack_s2 <= 1'b0;
    end else begin
      r_ireq_s1 <= i0_req;
      r_ireq_s2 <= r_ireq_s1;
      r_oack_s1 <= o0_ack;
      r_oack_s2 <= r_oack_s1;
    end
  end

  // Input handshake; a full FIFO simply withholds the ack until a slot opens.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i0_ack <= 1'b0;
      r_wptr   <= '0;
    end else if (w_wr) begin
      r_i0_ack <= 1'b1;
      r_wptr   <= r_wptr + 1'b1;
    end else if (!r_ireq_s2 && r_i0_ack) begin
      r_i0_ack <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {i0_red, i0_dat, i0_dst, i0_src};
  end

  always_ff @(posedge clk) begin
    if (reset) r_rptr <= '0;
    else if (w_pop) r_rptr <= r_rptr + 1'b1;
  end

  // Packets leave from the bottom of the shift register; it moves one packet per WAIT_LO exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_o0_req <= 1'b0;
      r_pakio  <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) r_state <= S_LOAD;
        S_LOAD: begin
          r_shift <= SH_SZ'(r_mem[r_rptr[AW-1:0]]);
          r_idx   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: if (!r_oack_s2) begin
          r_pakio  <= r_shift[PSZ-1:0];
          r_o0_req <= 1'b1;
          r_state  <= S_WAIT_HI;
        end
        S_WAIT_HI: if (r_oack_s2) begin
          r_o0_req <= 1'b0;
          r_state  <= S_WAIT_LO;
        end
        S_WAIT_LO: if (!r_oack_s2) begin
          if (r_idx == IW'(TOT_PKS-1)) begin
            r_state <= w_empty ? S_IDLE : S_LOAD;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_shift <= r_shift >> PSZ;
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
